// File: rtl/mux_nx1_arb.sv
// N-to-1 valid/ready mux with a registered single-entry output stage.
// Source is a fixed select or a round-robin arbiter chosen by mode.
module mux_nx1_arb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    grant
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  grant_q, grant_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             accept_ok;
  logic [N-1:0]     rot;
  logic             rr_found;
  int               rr_idx;
  logic [SELW-1:0]  rr_win;
  logic             sel_ok;
  logic [SELW-1:0]  src;
  logic [WIDTH-1:0] src_data;
  logic             xfer;

  assign accept_ok = !out_valid_q || out_ready;

  // Rotate valids so bit 0 is the channel at ptr; first set bit wins.
  always_comb begin
    rot      = N'({in_valid, in_valid} >> ptr_q);
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 0; k < N; k++) begin
      if (!rr_found && rot[k]) begin
        rr_found = 1'b1;
        rr_idx   = k + int'(ptr_q);
      end
    end
    if (rr_idx >= N) rr_idx = rr_idx - N;
    rr_win = SELW'(rr_idx);
  end

  always_comb begin
    sel_ok   = int'(sel) < N;
    src      = '0;
    in_ready = '0;
    if (!rst) begin
      if (mode) begin
        if (rr_found) begin
          src      = rr_win;
          in_ready = {{(N-1){1'b0}}, accept_ok} << rr_win;
        end
      end else if (sel_ok) begin
        src      = sel;
        in_ready = {{(N-1){1'b0}}, accept_ok} << sel;
      end
    end
  end

  assign xfer     = |(in_valid & in_ready);
  assign src_data = WIDTH'(in_data >> (int'(src) * WIDTH));

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = src_data;
      grant_d     = src;
      if (mode) begin
        ptr_d = (int'(src) == N - 1) ? '0 : src + 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Randomized + directed bench for mux_nx1_arb against a behavioural model.
// A second N=3 instance covers the out-of-range fixed select.
module tb_mux_nx1_arb;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [1:0]      sel;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      grant;

  logic [N3*W-1:0] in_data3;
  logic [N3-1:0]   in_valid3;
  logic [N3-1:0]   in_ready3;
  logic [1:0]      sel3;
  logic [W-1:0]    out_data3;
  logic            out_valid3;
  logic [1:0]      grant3;

  int n_cmp = 0;
  int n_err = 0;

  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_grant;
  int           m_ptr;

  always #5 clk = ~clk;

  mux_nx1_arb #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant)
  );

  mux_nx1_arb #(.WIDTH(W), .N(N3)) dut3 (
    .clk(clk), .rst(rst),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(1'b0), .sel(sel3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(1'b1),
    .grant(grant3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Which channel the rules say is taken this cycle (-1 = none).
  function automatic int m_pick();
    if (rst) return -1;
    if (m_valid && !out_ready) return -1;
    if (!mode) return (int'(sel) < N) ? int'(sel) : -1;
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    int c;
    logic [N-1:0] r;
    c = m_pick();
    r = '0;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  task automatic m_step();
    int c;
    c = m_pick();
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_grant = 0;
      m_ptr   = 0;
    end else if (c >= 0 && in_valid[c]) begin
      m_valid = 1'b1;
      m_data  = in_data[c*W +: W];
      m_grant = c;
      if (mode) m_ptr = (c + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    m_step();
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("grant", 32'(grant), 32'(m_grant));
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] d);
    in_data[c*W +: W] = d;
  endtask

  initial begin
    int exp_seq [6] = '{0, 1, 2, 3, 0, 1};
    m_valid   = 1'b0;
    m_data    = '0;
    m_grant   = 0;
    m_ptr     = 0;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    in_data3  = {16'h0333, 16'h0222, 16'h0111};
    in_valid3 = 3'b111;
    sel3      = 2'd3;

    #1;
    tick();
    in_valid = 4'hF;
    #1 chk("rst_ready", 32'(in_ready), 32'h0);
    tick();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);

    // fixed pass-through
    rst      = 1'b0;
    sel      = 2'd2;
    in_valid = 4'b0100;
    set_ch(2, 16'h0032);
    #1 chk("fix_ready", 32'(in_ready), 32'h4);
    tick();
    chk("fix_data", 32'(out_data), 32'h32);
    chk("fix_grant", 32'(grant), 32'h2);

    // backpressure
    out_ready = 1'b0;
    sel       = 2'd1;
    in_valid  = 4'b0010;
    set_ch(1, 16'h0028);
    #1 chk("bp_ready", 32'(in_ready), 32'h0);
    tick();
    chk("bp_hold", 32'(out_data), 32'h32);
    out_ready = 1'b1;
    tick();
    chk("bp_data", 32'(out_data), 32'h28);
    chk("bp_valid", 32'(out_valid), 32'h1);
    in_valid = '0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_hold", 32'(out_data), 32'h28);

    // round-robin fairness
    mode     = 1'b1;
    in_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      set_ch(0, 16'(i * 4 + 0));
      set_ch(1, 16'(i * 4 + 1));
      set_ch(2, 16'(i * 4 + 2));
      set_ch(3, 16'(i * 4 + 3));
      tick();
      chk("rr_seq", 32'(grant), 32'(exp_seq[i]));
    end

    // wrap and skip: land ptr on 3 first
    in_valid = 4'b0100;
    tick();
    chk("rr_to3", 32'(grant), 32'h2);
    in_valid = 4'b0011;
    tick();
    chk("rr_wrap", 32'(grant), 32'h0);
    tick();
    chk("rr_next", 32'(grant), 32'h1);
    in_valid = 4'hF;
    tick();
    chk("rr_ptr2", 32'(grant), 32'h2);

    // reset mid-stream
    rst = 1'b1;
    tick();
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_data", 32'(out_data), 32'h0);
    chk("mid_grant", 32'(grant), 32'h0);
    rst = 1'b0;
    set_ch(1, 16'h0AA1);
    tick();
    chk("post_rst_grant", 32'(grant), 32'h0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      in_data   = {$urandom(), $urandom()};
      in_valid  = 4'($urandom());
      mode      = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // N=3 instance: select 3 is out of range
    chk("n3_ready", 32'(in_ready3), 32'h0);
    chk("n3_valid", 32'(out_valid3), 32'h0);
    sel3 = 2'd2;
    @(posedge clk);
    #1;
    chk("n3_sel2_valid", 32'(out_valid3), 32'h1);
    chk("n3_sel2_data", 32'(out_data3), 32'h0333);
    chk("n3_sel2_grant", 32'(grant3), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
